// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the fetch stage of the 5-stage ARM pipeline:
//   NOP_INSTR           - encoding loaded into IF/ID for a bubble
//   IMEM_BYTES_DEFAULT  - default instruction ROM size in bytes
//   if_id_t             - contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR          = 32'hD503201F;
    localparam int          IMEM_BYTES_DEFAULT = 1024;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_chk.sv
// -----------------------------------------------------------------------------
// fetch_stage_chk
// Assertion checker for fetch_stage: redirect targets must be word-aligned,
// RESET_PC must be word-aligned, IMEM_BYTES must be a power of two above 4.
// Ports:
//   clk          in  system clock
//   reset        in  synchronous active-high reset
//   br_taken     in  redirect request
//   br_target_lo in  low two bits of the redirect target
// -----------------------------------------------------------------------------
module fetch_stage_chk #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = 1024
) (
    input logic       clk,
    input logic       reset,
    input logic       br_taken,
    input logic [1:0] br_target_lo
);

    localparam logic [1:0] RESET_PC_LO_C = RESET_PC[1:0];
    localparam bit IMEM_OK_C = (IMEM_BYTES > 4) &&
                               ((IMEM_BYTES & (IMEM_BYTES - 1)) == 0);

    // Misaligned redirect targets are a bug in the branch-resolution stage.
    assert property (@(posedge clk) disable iff (reset)
                     br_taken |-> (br_target_lo == 2'b00))
        else $error("fetch_stage: misaligned br_target");

    // Configuration sanity, sampled every cycle.
    assert property (@(posedge clk) (RESET_PC_LO_C == 2'b00) && IMEM_OK_C)
        else $error("fetch_stage: bad RESET_PC or IMEM_BYTES");

endmodule

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter register with load enable and load value.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset, loads RESET_PC
//   load_en   in   1 = capture load_val at the next posedge, 0 = hold
//   load_val  in   next PC value (word-aligned)
//   pc        out  current PC (registered)
// -----------------------------------------------------------------------------
module pc_reg #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic [63:0] load_val,
    output logic [63:0] pc
);

    logic [63:0] pc_r;

    // PC state: reset value, new load value, or hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else if (load_en) begin
            pc_r <= load_val;
        end else begin
            pc_r <= pc_r;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, addresses the combinational
// instruction ROM and captures {pc, instr, valid} into the IF/ID register.
// Priority each posedge: reset > br_taken > stall > normal fetch.
// Optional macro FETCH_BOUNDS_EN: halt fetch (bubbles, PC held) when the
// PC leaves the ROM; a redirect resumes fetch. Undefined: halted is 0.
// Ports:
//   clk          in   system clock
//   reset        in   synchronous active-high reset
//   stall        in   hold PC and IF/ID
//   br_taken     in   redirect to br_target and flush IF/ID
//   br_target    in   redirect byte address (word-aligned)
//   imem_addr    out  ROM byte address (= PC register)
//   imem_instr   in   ROM word for imem_addr
//   if_id_pc     out  PC of the IF/ID instruction
//   if_id_instr  out  IF/ID instruction
//   if_id_valid  out  IF/ID holds a real instruction
//   halted       out  fetch stopped on out-of-range PC
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int          IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted
);

    localparam if_id_t BUBBLE_C = '{pc: 64'd0, instr: NOP_INSTR, valid: 1'b0};

    logic [63:0] pc_s;
    logic [63:0] pc_next_s;
    logic        pc_en_s;
    logic [63:0] target_s;
    logic        stop_s;
    if_id_t      if_id_r;

    // Low bits are forced to zero so the PC stays aligned even on a bad target.
    assign target_s = {br_target[63:2], 2'b00};

`ifdef FETCH_BOUNDS_EN
    logic        halted_r;
    logic        oor_s;
    logic [64:0] pc_end_s;

    // 65-bit sum so a PC near 2^64 still counts as out of range.
    assign pc_end_s = {1'b0, pc_s} + 65'd3;
    assign oor_s    = (pc_end_s >= 65'(IMEM_BYTES));
    assign stop_s   = halted_r | oor_s;
`else
    assign stop_s   = 1'b0;
`endif

    // Next-PC selection.
    always_comb begin
        pc_en_s   = 1'b0;
        pc_next_s = pc_s;
        if (br_taken) begin
            pc_en_s   = 1'b1;
            pc_next_s = target_s;
        end else if (stall || stop_s) begin
            pc_en_s   = 1'b0;
            pc_next_s = pc_s;
        end else begin
            pc_en_s   = 1'b1;
            pc_next_s = pc_s + 64'd4;
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load_en  (pc_en_s),
        .load_val (pc_next_s),
        .pc       (pc_s)
    );

    // IF/ID pipeline register: flush on redirect or halt, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_r <= BUBBLE_C;
        end else if (br_taken) begin
            if_id_r <= BUBBLE_C;
        end else if (stall) begin
            if_id_r <= if_id_r;
        end else if (stop_s) begin
            if_id_r <= BUBBLE_C;
        end else begin
            if_id_r <= '{pc: pc_s, instr: imem_instr, valid: 1'b1};
        end
    end

`ifdef FETCH_BOUNDS_EN
    // Halt flag: set on an out-of-range normal fetch, cleared by redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_r <= 1'b0;
        end else if (br_taken) begin
            halted_r <= 1'b0;
        end else if (stall) begin
            halted_r <= halted_r;
        end else begin
            halted_r <= stop_s;
        end
    end

    assign halted = halted_r;
`else
    assign halted = 1'b0;
`endif

    assign imem_addr   = pc_s;
    assign if_id_pc    = if_id_r.pc;
    assign if_id_instr = if_id_r.instr;
    assign if_id_valid = if_id_r.valid;

    fetch_stage_chk #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .br_taken     (br_taken),
        .br_target_lo (br_target[1:0])
    );

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The ROM model returns 32'hE000_0000 with the
// low 16 address bits in the low half, so expected words are easy to derive.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .if_id_pc    (if_id_pc),
        .if_id_instr (if_id_instr),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    // ROM model
    assign imem_instr = {16'hE000, imem_addr[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One posedge, then settle to the following negedge for sampling.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 64'd0;
        step();
        step();
        check("rst_addr",   imem_addr,   64'd0);
        check("rst_pc",     if_id_pc,    64'd0);
        check("rst_instr",  if_id_instr, {32'd0, NOP_INSTR});
        check("rst_valid",  if_id_valid, 64'd0);
        check("rst_halted", halted,      64'd0);

        // Normal fetch after reset release
        reset = 1'b0;
        check("rel_addr0", imem_addr, 64'd0);
        step();
        check("seq_addr4",   imem_addr,   64'd4);
        check("seq_pc0",     if_id_pc,    64'd0);
        check("seq_valid1",  if_id_valid, 64'd1);
        check("seq_instr0",  if_id_instr, 64'hE0000000);
        step();
        check("seq_addr8",  imem_addr,   64'd8);
        check("seq_pc4",    if_id_pc,    64'd4);
        check("seq_instr4", if_id_instr, 64'hE0000004);

        // Two-cycle stall at PC 8
        stall = 1'b1;
        step();
        check("stl1_addr",  imem_addr,   64'd8);
        check("stl1_pc",    if_id_pc,    64'd4);
        check("stl1_instr", if_id_instr, 64'hE0000004);
        step();
        check("stl2_addr",  imem_addr,   64'd8);
        check("stl2_pc",    if_id_pc,    64'd4);
        check("stl2_valid", if_id_valid, 64'd1);
        stall = 1'b0;
        step();
        check("res_addr12", imem_addr,   64'd12);
        check("res_pc8",    if_id_pc,    64'd8);
        check("res_instr8", if_id_instr, 64'hE0000008);

        // Branch at PC 12 to 40
        br_taken  = 1'b1;
        br_target = 64'd40;
        step();
        check("br_addr40",  imem_addr,   64'd40);
        check("br_valid0",  if_id_valid, 64'd0);
        check("br_nop",     if_id_instr, {32'd0, NOP_INSTR});
        check("br_pc0",     if_id_pc,    64'd0);
        br_taken = 1'b0;
        step();
        check("br_addr44",  imem_addr,   64'd44);
        check("br_pc40",    if_id_pc,    64'd40);
        check("br_valid1",  if_id_valid, 64'd1);
        check("br_instr40", if_id_instr, 64'hE0000028);

        // Stall and branch together: branch wins
        stall     = 1'b1;
        br_taken  = 1'b1;
        br_target = 64'd100;
        step();
        check("sb_addr100", imem_addr,   64'd100);
        check("sb_valid0",  if_id_valid, 64'd0);
        check("sb_nop",     if_id_instr, {32'd0, NOP_INSTR});
        stall    = 1'b0;
        br_taken = 1'b0;
        step();
        check("sb_addr104", imem_addr,   64'd104);
        check("sb_pc100",   if_id_pc,    64'd100);
        check("sb_instr",   if_id_instr, 64'hE0000064);

        // Back-to-back redirects: last target wins
        br_taken  = 1'b1;
        br_target = 64'd200;
        step();
        br_target = 64'd300;
        step();
        check("bb_addr300", imem_addr,   64'd300);
        check("bb_valid0",  if_id_valid, 64'd0);
        br_taken = 1'b0;
        step();
        check("bb_addr304", imem_addr, 64'd304);
        check("bb_pc300",   if_id_pc,  64'd300);

        // Reset during a stall at PC 20
        br_taken  = 1'b1;
        br_target = 64'd20;
        step();
        br_taken = 1'b0;
        stall    = 1'b1;
        step();
        check("rs_addr20", imem_addr, 64'd20);
        reset = 1'b1;
        step();
        check("rs_addr0",  imem_addr,   64'd0);
        check("rs_valid0", if_id_valid, 64'd0);
        check("rs_halted", halted,      64'd0);
        check("rs_pc0",    if_id_pc,    64'd0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        check("rs_addr4", imem_addr, 64'd4);

`ifdef FETCH_BOUNDS_EN
        // Run off the end of the ROM, then redirect back in range
        br_taken  = 1'b1;
        br_target = 64'd1020;
        step();
        check("bd_addr1020", imem_addr, 64'd1020);
        check("bd_halt0",    halted,    64'd0);
        br_taken = 1'b0;
        step();
        check("bd_addr1024", imem_addr,   64'd1024);
        check("bd_pc1020",   if_id_pc,    64'd1020);
        check("bd_valid1",   if_id_valid, 64'd1);
        check("bd_halt0b",   halted,      64'd0);
        step();
        check("bd_halt1",    halted,      64'd1);
        check("bd_hold1024", imem_addr,   64'd1024);
        check("bd_bubble",   if_id_valid, 64'd0);
        check("bd_nop",      if_id_instr, {32'd0, NOP_INSTR});
        step();
        check("bd_halt1b",   halted,    64'd1);
        check("bd_hold2",    imem_addr, 64'd1024);
        br_taken  = 1'b1;
        br_target = 64'd0;
        step();
        check("bd_unhalt",  halted,    64'd0);
        check("bd_addr0",   imem_addr, 64'd0);
        br_taken = 1'b0;
        step();
        check("bd_addr4",   imem_addr,   64'd4);
        check("bd_pc0",     if_id_pc,    64'd0);
        check("bd_valid1b", if_id_valid, 64'd1);
`else
        // PC wraps modulo 2^64
        br_taken  = 1'b1;
        br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check("wr_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        br_taken = 1'b0;
        step();
        check("wr_addr0",  imem_addr,   64'd0);
        check("wr_pc_top", if_id_pc,    64'hFFFF_FFFF_FFFF_FFFC);
        check("wr_instr",  if_id_instr, 64'hE000FFFC);
        check("wr_halt0",  halted,      64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
